// File: rtl/fxp64_pkg.sv
// Shared constants and state encoding for the FXP64 accumulator datapath.
// Fixed-point values are 64-bit two's complement; the Q format is informational.
package fxp64_pkg;

  localparam int FXP64_WIDTH = 64;

  localparam logic [FXP64_WIDTH-1:0] FXP64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [FXP64_WIDTH-1:0] FXP64_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } fxp64_state_t;

endpackage

// File: rtl/cla_64bit.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
// Reports signed overflow as carry-in XOR carry-out of the sign bit.
module cla_64bit (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_cin,
  output logic [63:0] o_sum,
  output logic        o_ovf
);

  logic [63:0] w_g;
  logic [63:0] w_p;
  logic [15:0] w_gg;
  logic [15:0] w_gp;
  logic [64:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  for (genvar k = 0; k < 16; k++) begin : g_grp
    assign w_gg[k] = w_g[4*k+3]
                   | (w_p[4*k+3] & w_g[4*k+2])
                   | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                   | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    assign w_gp[k] = &w_p[4*k+3:4*k];
  end

  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 3; j++) begin
        w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
      end
      w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
    end
  end

  assign o_sum = w_p ^ w_c[63:0];
  assign o_ovf = w_c[64] ^ w_c[63];

endmodule

// File: rtl/fxp64_sat.sv
// Clamps an adder result to the signed 64-bit range on overflow.
// The old accumulator sign picks which rail the overflow ran into.
module fxp64_sat
  import fxp64_pkg::*;
(
  input  logic [FXP64_WIDTH-1:0] i_sum,
  input  logic                   i_ovf,
  input  logic                   i_sign,
  output logic [FXP64_WIDTH-1:0] o_val,
  output logic                   o_sat
);

  assign o_sat = i_ovf;
  assign o_val = !i_ovf ? i_sum :
                 i_sign ? FXP64_MIN : FXP64_MAX;

endmodule

// File: rtl/fxp64_accum.sv
// Streaming saturating accumulator: sums or differences len operands
// through the CLA and hands the result downstream with valid/ready.
module fxp64_accum
  import fxp64_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int FRAC_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [LEN_W-1:0]       in_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FXP64_WIDTH-1:0] in_data,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FXP64_WIDTH-1:0] out_sum,
  output logic                   out_sat,
  output logic                   busy
);

  if (FRAC_BITS < 0 || FRAC_BITS >= FXP64_WIDTH) begin : g_frac_chk
    $error("FRAC_BITS must lie within the 64-bit word");
  end

  fxp64_state_t           r_state;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_cnt;
  logic [FXP64_WIDTH-1:0] r_acc;
  logic                   r_sat;

  logic [FXP64_WIDTH-1:0] w_b;
  logic [FXP64_WIDTH-1:0] w_sum;
  logic                   w_ovf;
  logic [FXP64_WIDTH-1:0] w_next;
  logic                   w_sat_hit;
  logic                   w_last;

  // Subtraction is a + ~b + 1 through the same adder.
  assign w_b = in_sub ? ~in_data : in_data;

  cla_64bit u_add (
    .i_a   (r_acc),
    .i_b   (w_b),
    .i_cin (in_sub),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  fxp64_sat u_sat (
    .i_sum  (w_sum),
    .i_ovf  (w_ovf),
    .i_sign (r_acc[FXP64_WIDTH-1]),
    .o_val  (w_next),
    .o_sat  (w_sat_hit)
  );

  assign w_last = (r_cnt == r_len - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_start) begin
            r_len   <= in_len;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_state <= (in_len == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            r_acc <= w_next;
            r_sat <= r_sat | w_sat_hit;
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ACC) || (r_state == DONE);
  assign out_sum   = r_acc;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_fxp64_accum.sv
// Randomised and directed bench for fxp64_accum against an exact-arithmetic
// model that clamps the true sum to the signed 64-bit range.
module tb_fxp64_accum;

  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic signed [65:0] EMAX = 66'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] EMIN = -EMAX - 66'sd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start;
  logic [15:0] in_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_sat;
  logic        busy;

  int vectors = 0;
  int errors  = 0;
  int gap_pct = 0;

  logic [63:0] q_data[$];
  logic        q_sub[$];

  fxp64_accum #(.LEN_W(16), .FRAC_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_start  (in_start),
    .in_len    (in_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact sum of the job, clamped to the representable range at each step.
  function automatic logic [64:0] model_job();
    logic signed [65:0] acc;
    logic signed [65:0] d;
    logic               sat;
    acc = '0;
    sat = 1'b0;
    for (int i = 0; i < q_data.size(); i++) begin
      d   = {{2{q_data[i][63]}}, q_data[i]};
      acc = q_sub[i] ? acc - d : acc + d;
      if (acc > EMAX) begin
        acc = EMAX;
        sat = 1'b1;
      end else if (acc < EMIN) begin
        acc = EMIN;
        sat = 1'b1;
      end
    end
    return {sat, acc[63:0]};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(7))
      0: v = MAX64 - 64'($urandom_range(15));
      1: v = MIN64 + 64'($urandom_range(15));
      2: v = 64'($urandom_range(255));
      default: ;
    endcase
    return v;
  endfunction

  task automatic do_job(input int len, input logic hold_ready,
                        output logic [63:0] s_obs, output logic sat_obs,
                        output logic pre_vld, output logic post_vld,
                        output int rdy_miss);
    rdy_miss = 0;
    pre_vld  = 1'b0;
    in_start = 1'b1;
    in_len   = 16'(len);
    tick();
    in_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = q_data[i];
      in_sub   = q_sub[i];
      if (!in_ready) rdy_miss++;
      if (i == len - 1) pre_vld = out_valid;
      tick();
    end
    in_valid = 1'b0;
    post_vld = out_valid;
    s_obs    = out_sum;
    sat_obs  = out_sat;
    if (!hold_ready) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if ({in_ready, out_valid, busy, out_sat, out_sum} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b sat=%b sum=%h want all 0",
               in_ready, out_valid, busy, out_sat, out_sum);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] s;
    logic        sat, pre, post;
    int          miss;
    gap_pct = 0;
    q_data  = '{64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000,
                64'h0000_0003_0000_0000};
    q_sub   = '{1'b0, 1'b0, 1'b0};
    do_job(3, 1'b0, s, sat, pre, post, miss);
    vectors++;
    if (s !== 64'h0000_0006_0000_0000 || sat !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sum got %h sat %b want 0000000600000000 sat 0", s, sat);
    end
    vectors++;
    if (pre !== 1'b0 || post !== 1'b1 || miss != 0) begin
      errors++;
      $display("FAIL b2b_latency vld_before=%b vld_after=%b rdy_miss=%0d want 0 1 0",
               pre, post, miss);
    end
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] a[3];
    logic [63:0] b[3];
    logic        bs[3];
    logic [63:0] es[3];
    logic        esat[3];
    logic [63:0] s;
    logic        sat, pre, post;
    int          miss;
    a    = '{64'h7FFF_FFFF_FFFF_FFF0, 64'h0, 64'hFFFF_FFFF_0000_0000};
    b    = '{64'h20, MIN64, 64'h0000_0001_0000_0000};
    bs   = '{1'b0, 1'b1, 1'b1};
    es   = '{MAX64, MAX64, 64'hFFFF_FFFE_0000_0000};
    esat = '{1'b1, 1'b1, 1'b0};
    gap_pct = 0;
    for (int t = 0; t < 3; t++) begin
      q_data = '{a[t], b[t]};
      q_sub  = '{1'b0, bs[t]};
      do_job(2, 1'b0, s, sat, pre, post, miss);
      vectors++;
      if (s !== es[t] || sat !== esat[t] || post !== 1'b1) begin
        errors++;
        $display("FAIL sat_case%0d got sum %h sat %b vld %b want %h sat %b vld 1",
                 t, s, sat, post, es[t], esat[t]);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [63:0] s;
    logic        sat, pre, post;
    int          miss;
    q_data.delete();
    q_sub.delete();
    do_job(0, 1'b0, s, sat, pre, post, miss);
    vectors++;
    if (post !== 1'b1 || s !== 64'd0) begin
      errors++;
      $display("FAIL zero_len vld=%b sum=%h want vld 1 sum 0", post, s);
    end
  endtask

  task automatic test_hold();
    logic [63:0] s;
    logic        sat, pre, post;
    logic [64:0] exp;
    int          miss;
    gap_pct = 0;
    q_data  = '{rand_op(), rand_op()};
    q_sub   = '{1'($urandom_range(1)), 1'($urandom_range(1))};
    exp     = model_job();
    do_job(2, 1'b1, s, sat, pre, post, miss);
    for (int c = 0; c < 5; c++) begin
      in_start = (c == 2);
      in_len   = 16'd3;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== exp[63:0] || out_sat !== exp[64]
          || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_c%0d vld=%b sum=%h sat=%b rdy=%b busy=%b want 1 %h %b 0 1",
                 c, out_valid, out_sum, out_sat, in_ready, busy, exp[63:0], exp[64]);
      end
    end
    out_ready = 1'b1;
    in_start  = 1'b1;
    tick();
    out_ready = 1'b0;
    in_start  = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release vld=%b busy=%b want 0 0", out_valid, busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || out_sum !== exp[63:0] || out_sat !== exp[64]) begin
      errors++;
      $display("FAIL hold_idle busy=%b sum=%h sat=%b want 0 %h %b",
               busy, out_sum, out_sat, exp[63:0], exp[64]);
    end
  endtask

  task automatic test_reset_midjob();
    logic [63:0] s;
    logic        sat, pre, post;
    int          miss;
    in_start = 1'b1;
    in_len   = 16'd4;
    tick();
    in_start = 1'b0;
    in_valid = 1'b1;
    in_sub   = 1'b0;
    in_data  = MAX64;
    tick();
    in_data  = 64'd1;
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, out_sat, out_sum} !== 68'd0) begin
      errors++;
      $display("FAIL midjob_reset rdy=%b vld=%b busy=%b sat=%b sum=%h want all 0",
               in_ready, out_valid, busy, out_sat, out_sum);
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    gap_pct = 0;
    q_data  = '{64'd5};
    q_sub   = '{1'b0};
    do_job(1, 1'b0, s, sat, pre, post, miss);
    vectors++;
    if (s !== 64'd5 || sat !== 1'b0 || post !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_job sum=%h sat=%b vld=%b want 5 0 1", s, sat, post);
    end
  endtask

  task automatic test_random();
    logic [63:0] s;
    logic        sat, pre, post;
    logic [64:0] exp;
    int          miss, len, dly;
    gap_pct = 30;
    for (int j = 0; j < 40; j++) begin
      len = $urandom_range(1, 10);
      q_data.delete();
      q_sub.delete();
      for (int i = 0; i < len; i++) begin
        q_data.push_back(rand_op());
        q_sub.push_back(1'($urandom_range(1)));
      end
      exp = model_job();
      do_job(len, 1'b1, s, sat, pre, post, miss);
      vectors++;
      if (s !== exp[63:0] || sat !== exp[64]) begin
        errors++;
        $display("FAIL rand_job%0d len %0d sum=%h sat=%b want %h %b",
                 j, len, s, sat, exp[63:0], exp[64]);
      end
      vectors++;
      if (pre !== 1'b0 || post !== 1'b1 || miss != 0) begin
        errors++;
        $display("FAIL rand_timing%0d vld_before=%b vld_after=%b rdy_miss=%0d want 0 1 0",
                 j, pre, post, miss);
      end
      dly = $urandom_range(0, 2);
      repeat (dly) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || out_sum !== exp[63:0]) begin
        errors++;
        $display("FAIL rand_drain%0d vld=%b sum=%h want 0 %h",
                 j, out_valid, out_sum, exp[63:0]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_start  = 1'b0;
    in_len    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_saturation();
    test_zero_len();
    test_hold();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fxp64_accum.md
Name: fxp64_accum

Overview:
- Streaming 64-bit signed fixed-point accumulator that sits directly downstream of the 64-bit carry-lookahead adder.
- Sums, or differences, a programmed number of operands in a feedback loop through that adder and saturates on signed overflow.
- Presents the final sum with a valid/ready handshake to the next datapath stage.
- Primary consumer of adder sum/overflow results in the FXP64 datapath.

Parameters:
- LEN_W, 16, width of the sample-count field; one job accumulates up to 2^LEN_W-1 operands.
- FRAC_BITS, 32, fractional bits of the Q format. Informational only; the datapath is format-agnostic.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_start  in  1  job start pulse; honoured only in IDLE.
- in_len  in  LEN_W  number of operands in the job; sampled with in_start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand ready.
- in_data  in  64  signed two's-complement operand.
- in_sub  in  1  qualifies in_data: 1 = subtract, 0 = add.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  64  accumulated, saturated result.
- out_sat  out  1  sticky flag: saturation occurred at least once during the job.
- busy  out  1  high in ACC and DONE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - acc, count, out_sum, out_sat = 0.
  - in_ready, out_valid, busy = 0.
- States:
  - IDLE:
    - in_start with in_len != 0: latch len, clear acc, count and out_sat, go to ACC.
    - in_start with in_len == 0: set acc = 0, go to DONE. out_valid rises on the next cycle.
  - ACC:
    - in_ready = 1 combinationally.
    - Accept on in_valid && in_ready, at most one operand per cycle; acc updates at the same edge.
    - Add path: adder b = in_data, carry-in = 0.
    - Subtract path: adder b = ~in_data, carry-in = 1.
    - Overflow flag V = (carry into bit 63) XOR (carry out of bit 63), taken from the adder.
    - V = 0: acc <= sum.
    - V = 1: acc <= 0x7FFF_FFFF_FFFF_FFFF if the old acc[63] = 0, else 0x8000_0000_0000_0000; set out_sat.
    - count increments on each accept. The accept with count == len-1 moves to DONE.
  - DONE:
    - out_valid = 1; out_sum = acc, held stable; in_ready = 0.
    - out_valid && out_ready: go to IDLE; out_valid drops on the next cycle.
- Latency: out_valid is asserted the cycle after the last accept.
- Throughput: 1 operand per cycle with in_valid held high. Minimum job length is len+2 cycles, including the handshake.
- in_start is ignored in ACC and DONE. in_start coincident with the DONE->IDLE handshake is ignored.
- in_valid gaps in ACC: state and count hold. There is no timeout.
- out_sum and out_sat remain stable while out_valid && !out_ready, and after return to IDLE until the next start.
- -2^63 subtracted from a non-negative acc overflows and saturates positive.
- count is LEN_W bits wide and never wraps, because len <= 2^LEN_W-1.
- Reset asserted mid-job aborts the job; no partial result is emitted.

Decomposition:
- Shared package fxp64_pkg holds:
  - FXP64_WIDTH = 64.
  - FXP64_MAX = 0x7FFF_FFFF_FFFF_FFFF.
  - FXP64_MIN = 0x8000_0000_0000_0000.
  - state encoding: IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2.
- The existing cla_64bit is instantiated as the combinational adder core.
- One new sub-module, fxp64_sat, is natural. It is combinational: inputs are sum, V and the old sign; outputs are the clamped value and a sat flag.
- The FSM, counter and registers live in fxp64_accum.

Test Plan:
- Start with in_len=3; add 0x0000_0001_0000_0000, 0x0000_0002_0000_0000, 0x0000_0003_0000_0000 back-to-back. Expect out_sum = 0x0000_0006_0000_0000, out_sat = 0, out_valid exactly 1 cycle after the 3rd accept.
- in_len=2; add 0x7FFF_FFFF_FFFF_FFF0, then add 0x20. Expect out_sum = 0x7FFF_FFFF_FFFF_FFFF, out_sat = 1.
- in_len=2; add 0x0, then subtract 0x8000_0000_0000_0000. Expect out_sum = 0x7FFF_FFFF_FFFF_FFFF, out_sat = 1.
- in_len=2; add 0xFFFF_FFFF_0000_0000, then subtract 0x0000_0001_0000_0000. Expect out_sum = 0xFFFF_FFFE_0000_0000, out_sat = 0.
- in_len=0 start: expect out_valid the next cycle with out_sum = 0.
- Hold out_ready low for 5 cycles and pulse in_start during DONE. Expect out_sum stable, in_ready = 0, start ignored; IDLE follows the first out_ready.
- in_len=4; assert rst after 2 accepts. Expect all outputs 0 in the same cycle. A subsequent in_len=1 job adding 0x5 gives out_sum = 0x5.
